alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter.sv | 226 ++++++++++++++++++++++
 tb/tb_alu_arbiter.sv | 464 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// -----------------------------------------------------------------------------
// alu_arbiter
//
// Purpose:
//   Two-requester round-robin front end for a single shared, purely
//   combinational ALU. A granted request has its operands and opcode
//   registered onto alu_a/alu_b/alu_op. One cycle later the ALU result is
//   captured into q, and q stays valid until the consumer acknowledges it.
//   Only one operation is in flight at a time. The sequence is
//   IDLE -> EXEC -> DONE -> IDLE.
//
// Parameters:
//   WIDTH    operand / ALU / result width in bits (default 32)
//
// Ports:
//   clk               single clock, rising edge
//   rst               synchronous active-high reset
//   req0/req1         request; held high with stable operands until granted
//   a0,b0/a1,b1       requester operands (WIDTH)
//   op0/op1           requester opcode (3 bits), passed through unchanged
//   gnt0/gnt1         one-cycle pulse: request accepted this cycle
//   alu_a, alu_b      registered operands driven to the shared ALU
//   alu_op            registered opcode driven to the shared ALU
//   alu_q             combinational ALU result for alu_a/alu_b/alu_op
//   q                 registered result (keeps its value after ack)
//   q_valid           q/q_id valid, held until q_ack
//   q_id              requester that owns q
//   q_ack             consumer accepts q; ignored while q_valid=0
//   busy              high while an operation is in EXEC or DONE
// -----------------------------------------------------------------------------
module alu_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic [2:0]       op0,
  output logic             gnt0,
  input  logic             req1,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  input  logic [2:0]       op1,
  output logic             gnt1,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_op,
  input  logic [WIDTH-1:0] alu_q,
  output logic [WIDTH-1:0] q,
  output logic             q_valid,
  output logic             q_id,
  input  logic             q_ack,
  output logic             busy
);

  localparam int NREQ = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  // ---------------------------------------------------------------------------
  // State and registered outputs
  // ---------------------------------------------------------------------------
  state_t           state_reg;
  logic             last_reg;     // requester granted most recently
  logic             owner_reg;    // requester owning the operation in flight
  logic [NREQ-1:0]  gnt_reg;
  logic [WIDTH-1:0] alu_a_reg;
  logic [WIDTH-1:0] alu_b_reg;
  logic [2:0]       alu_op_reg;
  logic [WIDTH-1:0] q_reg;
  logic             q_valid_reg;
  logic             q_id_reg;
  logic             busy_reg;

  // ---------------------------------------------------------------------------
  // Requester views as arrays so the selection logic is written once
  // ---------------------------------------------------------------------------
  logic [NREQ-1:0]  req_vec;
  logic [WIDTH-1:0] a_vec  [NREQ];
  logic [WIDTH-1:0] b_vec  [NREQ];
  logic [2:0]       op_vec [NREQ];

  assign req_vec   = {req1, req0};
  assign a_vec[0]  = a0;
  assign a_vec[1]  = a1;
  assign b_vec[0]  = b0;
  assign b_vec[1]  = b1;
  assign op_vec[0] = op0;
  assign op_vec[1] = op1;

  // ---------------------------------------------------------------------------
  // Arbitration
  //   With a single request, that requester wins. With both requests, the
  //   requester not served last wins. The winner is only used in IDLE with at
  //   least one request pending. Otherwise it is ignored.
  // ---------------------------------------------------------------------------
  logic            pick_id;
  logic [NREQ-1:0] sel_onehot;

  always_comb begin
    pick_id    = 1'b0;
    sel_onehot = '0;
    if (req_vec == 2'b11) begin
      pick_id = ~last_reg;
    end else begin
      pick_id = req_vec[1];
    end
    sel_onehot[pick_id] = 1'b1;
  end

  // ---------------------------------------------------------------------------
  // Operand select as an AND-OR mux driven by the one-hot winner
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] a_term  [NREQ];
  logic [WIDTH-1:0] b_term  [NREQ];
  logic [2:0]       op_term [NREQ];
  logic [WIDTH-1:0] a_sel;
  logic [WIDTH-1:0] b_sel;
  logic [2:0]       op_sel;

  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_sel
      assign a_term[gi]  = sel_onehot[gi] ? a_vec[gi]  : '0;
      assign b_term[gi]  = sel_onehot[gi] ? b_vec[gi]  : '0;
      assign op_term[gi] = sel_onehot[gi] ? op_vec[gi] : '0;
    end
  endgenerate

  assign a_sel  = a_term[0]  | a_term[1];
  assign b_sel  = b_term[0]  | b_term[1];
  assign op_sel = op_term[0] | op_term[1];

  // ---------------------------------------------------------------------------
  // Control FSM with registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      // Reset aborts any operation in flight. Its result is never produced
      // and the request is not replayed.
      state_reg   <= IDLE;
      last_reg    <= 1'b1;   // requester 0 wins the first tie
      owner_reg   <= 1'b0;
      gnt_reg     <= '0;
      alu_a_reg   <= '0;
      alu_b_reg   <= '0;
      alu_op_reg  <= 3'b000;
      q_reg       <= '0;
      q_valid_reg <= 1'b0;
      q_id_reg    <= 1'b0;
      busy_reg    <= 1'b0;
    end else begin
      gnt_reg <= '0;   // grants are single-cycle pulses
      unique case (state_reg)
        IDLE: begin
          if (|req_vec) begin
            alu_a_reg  <= a_sel;
            alu_b_reg  <= b_sel;
            alu_op_reg <= op_sel;
            gnt_reg    <= sel_onehot;
            owner_reg  <= pick_id;
            last_reg   <= pick_id;
            busy_reg   <= 1'b1;
            state_reg  <= EXEC;
          end
        end
        EXEC: begin
          // The ALU has had a full cycle on the registered operands.
          q_reg       <= alu_q;
          q_id_reg    <= owner_reg;
          q_valid_reg <= 1'b1;
          state_reg   <= DONE;
        end
        DONE: begin
          // q keeps its value after the ack. Only q_valid drops.
          if (q_ack) begin
            q_valid_reg <= 1'b0;
            busy_reg    <= 1'b0;
            state_reg   <= IDLE;
          end
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Output mapping
  // ---------------------------------------------------------------------------
  assign gnt0    = gnt_reg[0];
  assign gnt1    = gnt_reg[1];
  assign alu_a   = alu_a_reg;
  assign alu_b   = alu_b_reg;
  assign alu_op  = alu_op_reg;
  assign q       = q_reg;
  assign q_valid = q_valid_reg;
  assign q_id    = q_id_reg;
  assign busy    = busy_reg;

  // ---------------------------------------------------------------------------
  // Structural invariants
  // ---------------------------------------------------------------------------
  a_gnt_onehot : assert property (@(posedge clk) disable iff (rst)
    !(gnt_reg[0] && gnt_reg[1]));

  a_gnt_enters_exec : assert property (@(posedge clk) disable iff (rst)
    (gnt_reg != '0) |-> (state_reg == EXEC));

  a_busy_state : assert property (@(posedge clk) disable iff (rst)
    busy_reg == (state_reg != IDLE));

  a_valid_state : assert property (@(posedge clk) disable iff (rst)
    q_valid_reg == (state_reg == DONE));

  a_done_hold : assert property (@(posedge clk) disable iff (rst)
    (state_reg == DONE && !q_ack) |=>
      ($stable(q_reg) && $stable(q_id_reg) && $stable(alu_a_reg) &&
       $stable(alu_b_reg) && $stable(alu_op_reg) && q_valid_reg));

endmodule

// File: tb/tb_alu_arbiter.sv
// -----------------------------------------------------------------------------
// tb_alu_arbiter
//
// Purpose:
//   Self-checking bench for alu_arbiter. The bench also models the external
//   combinational ALU.
//
// Processes:
//   - Main stimulus: a sequence of directed scenarios, followed by two
//     randomized requesters and a random ack delay.
//   - Monitor (negative edge): a transaction-level model of the arbiter.
//     - On each grant, the monitor predicts the winner.
//     - The expected {id, result} for that grant is pushed onto a queue.
//     - When q_valid rises, the monitor pops the queue and compares.
//     - It also checks busy, q_valid level, result hold and latency.
//
// Inputs change 2 time units after the rising edge.
// Outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_alu_arbiter;

  localparam int W = 32;

  logic         clk;
  logic         rst;
  logic         req_t [2];
  logic [W-1:0] a_t   [2];
  logic [W-1:0] b_t   [2];
  logic [2:0]   op_t  [2];
  logic         gnt0, gnt1;
  logic [W-1:0] alu_a, alu_b, alu_q, q;
  logic [2:0]   alu_op;
  logic         q_valid, q_id, q_ack, busy;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference ALU: plain arithmetic, truncated to W bits.
  function automatic logic [W-1:0] ref_alu(input logic [W-1:0] a,
                                           input logic [W-1:0] b,
                                           input logic [2:0]   op);
    logic [W-1:0] r;
    case (op)
      3'd0:    r = a + b;
      3'd1:    r = a - b;
      3'd2:    r = a * b;
      3'd3:    r = a & b;
      3'd4:    r = a | b;
      3'd5:    r = ~(a & b);
      3'd6:    r = ~(a | b);
      default: r = ~a;
    endcase
    return r;
  endfunction

  function automatic logic [W-1:0] rand_operand();
    logic [W-1:0] v;
    case ($urandom_range(0, 3))
      0:       v = '0;
      1:       v = '1;
      default: v = $urandom;
    endcase
    return v;
  endfunction

  // Compare one value and report a FAIL line on a mismatch.
  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)",
               name, act, exp, $time);
    end
  endtask

  alu_arbiter #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst    (rst),
    .req0   (req_t[0]),
    .a0     (a_t[0]),
    .b0     (b_t[0]),
    .op0    (op_t[0]),
    .gnt0   (gnt0),
    .req1   (req_t[1]),
    .a1     (a_t[1]),
    .b1     (b_t[1]),
    .op1    (op_t[1]),
    .gnt1   (gnt1),
    .alu_a  (alu_a),
    .alu_b  (alu_b),
    .alu_op (alu_op),
    .alu_q  (alu_q),
    .q      (q),
    .q_valid(q_valid),
    .q_id   (q_id),
    .q_ack  (q_ack),
    .busy   (busy)
  );

  // External shared ALU
  always_comb alu_q = ref_alu(alu_a, alu_b, alu_op);

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at t=%0t, expected to have finished", $time);
    $fatal(1);
  end

  // ---------------------------------------------------------------------------
  // Input snapshot at each rising edge (what the DUT sampled)
  // ---------------------------------------------------------------------------
  logic         snap_rst;
  logic [1:0]   snap_req;
  logic [W-1:0] snap_a  [2];
  logic [W-1:0] snap_b  [2];
  logic [2:0]   snap_op [2];

  always @(posedge clk) begin
    snap_rst <= rst;
    snap_req <= {req_t[1], req_t[0]};
    for (int i = 0; i < 2; i++) begin
      snap_a[i]  <= a_t[i];
      snap_b[i]  <= b_t[i];
      snap_op[i] <= op_t[i];
    end
  end

  // ---------------------------------------------------------------------------
  // Scoreboard monitor
  // ---------------------------------------------------------------------------
  typedef struct packed {
    logic         id;
    logic [W-1:0] res;
  } exp_t;

  exp_t         sb [$];
  int           cyc         = 0;
  int           grant_cyc   = 0;
  bit           outstanding = 0;  // an accepted request has not been acked yet
  bit           ack_pending = 0;  // ack seen, takes effect at the coming edge
  bit           m_last      = 1;  // model round-robin pointer
  bit           prev_qv     = 0;
  logic [W-1:0] held_q      = '0;
  logic         held_id     = 1'b0;

  always @(negedge clk) begin
    bit       exp_g;
    bit       win;
    bit       exp_qv;
    logic [1:0] exp_gv;
    exp_t     e;
    cyc++;
    if (rst) begin
      sb.delete();
      outstanding = 0;
      ack_pending = 0;
      m_last      = 1;
      prev_qv     = 0;
      held_q      = '0;
      held_id     = 1'b0;
    end else begin
      exp_g = 0;
      win   = 0;
      if (!outstanding && !snap_rst && snap_req != 2'b00) begin
        exp_g = 1;
        win   = (snap_req == 2'b11) ? ~m_last : snap_req[1];
      end
      exp_gv = exp_g ? (win ? 2'b10 : 2'b01) : 2'b00;
      if (exp_gv != 2'b00 || {gnt1, gnt0} != 2'b00)
        check("gnt", {62'd0, gnt1, gnt0}, {62'd0, exp_gv});

      if (exp_g) begin
        outstanding = 1;
        m_last      = win;
        grant_cyc   = cyc;
        sb.push_back('{id: win,
                       res: ref_alu(snap_a[win], snap_b[win], snap_op[win])});
        check("alu_a",  alu_a,  snap_a[win]);
        check("alu_b",  alu_b,  snap_b[win]);
        check("alu_op", alu_op, snap_op[win]);
      end else if (ack_pending) begin
        ack_pending = 0;
        outstanding = 0;
      end

      check("busy", busy, outstanding);

      if (q_valid && !prev_qv) begin
        if (sb.size() == 0) begin
          check("q_valid_without_request", 1, 0);
        end else begin
          e = sb.pop_front();
          check("q",       q,    e.res);
          check("q_id",    q_id, e.id);
          check("latency", cyc - grant_cyc, 1);
          held_q  = e.res;
          held_id = e.id;
        end
      end else begin
        check("q_hold",    q,    held_q);
        check("q_id_hold", q_id, held_id);
      end

      exp_qv = outstanding && (cyc > grant_cyc);
      check("q_valid", q_valid, exp_qv);
      if (exp_qv && q_ack) ack_pending = 1;
      prev_qv = q_valid;
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_gnt(input int n, output bit got);
    got = 0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      if ((n == 0 && gnt0) || (n == 1 && gnt1)) got = 1;
    end
    if (!got) begin
      n_checks++;
      n_fail++;
      $display("FAIL gnt%0d_timeout: got no grant in 100 cycles, expected one", n);
    end
  endtask

  task automatic apply_reset();
    tick();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic set_req(input int n, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [2:0] op);
    a_t[n]   = a;
    b_t[n]   = b;
    op_t[n]  = op;
    req_t[n] = 1'b1;
  endtask

  task automatic drive_rand(input int n, input int count);
    bit got;
    for (int k = 0; k < count; k++) begin
      repeat ($urandom_range(0, 3)) tick();
      set_req(n, rand_operand(), rand_operand(), 3'($urandom_range(0, 7)));
      if ($urandom_range(0, 9) == 0) begin
        // Drop the request early. It is served only if the DUT grants it at that edge.
        tick();
        req_t[n] = 1'b0;
      end else begin
        wait_gnt(n, got);
        tick();
        req_t[n] = 1'b0;
      end
    end
  endtask

  bit rand_done = 0;

  // ---------------------------------------------------------------------------
  // Main stimulus
  // ---------------------------------------------------------------------------
  initial begin
    bit got;
    int gseen;
    int prev_k;
    int prev_id;
    int cur_id;
    int chg;
    bit pend;
    bit seen;

    rst = 1'b1;
    q_ack = 1'b1;
    for (int i = 0; i < 2; i++) begin
      req_t[i] = 1'b0;
      a_t[i]   = '0;
      b_t[i]   = '0;
      op_t[i]  = '0;
    end

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_gnt0",    gnt0,    0);
    check("rst_gnt1",    gnt1,    0);
    check("rst_q_valid", q_valid, 0);
    check("rst_q_id",    q_id,    0);
    check("rst_busy",    busy,    0);
    check("rst_q",       q,       0);
    check("rst_alu_a",   alu_a,   0);
    check("rst_alu_b",   alu_b,   0);
    check("rst_alu_op",  alu_op,  0);
    tick();
    rst = 1'b0;

    // Single add from requester 0, ack tied high
    set_req(0, 32'd5, 32'd3, 3'b000);
    wait_gnt(0, got);
    check("add_gnt1_quiet", gnt1, 0);
    tick();
    req_t[0] = 1'b0;
    @(negedge clk);
    check("add_q_valid", q_valid, 1);
    check("add_q",       q,       32'd8);
    check("add_q_id",    q_id,    0);
    tick();
    @(negedge clk);
    check("add_valid_one_cycle", q_valid, 0);

    // Tie from reset: requester 0 first, then requester 1 (multiply wraps)
    apply_reset();
    set_req(0, 32'd10, 32'd4, 3'b001);
    set_req(1, 32'h0001_0000, 32'h0001_0000, 3'b010);
    wait_gnt(0, got);
    check("tie_first_not_1", gnt1, 0);
    tick();
    req_t[0] = 1'b0;
    @(negedge clk);
    check("tie_sub_q",  q,    32'd6);
    check("tie_sub_id", q_id, 0);
    wait_gnt(1, got);
    tick();
    req_t[1] = 1'b0;
    @(negedge clk);
    check("tie_mul_q",     q,       32'd0);
    check("tie_mul_id",    q_id,    1);
    check("tie_mul_valid", q_valid, 1);
    repeat (3) tick();

    // Both held continuously with immediate ack: alternate, 3 cycles apart
    set_req(0, rand_operand(), rand_operand(), 3'($urandom_range(0, 7)));
    set_req(1, rand_operand(), rand_operand(), 3'($urandom_range(0, 7)));
    gseen   = 0;
    prev_k  = 0;
    prev_id = -1;
    chg     = 0;
    for (int k = 0; k < 60 && gseen < 6; k++) begin
      @(negedge clk);
      pend = 0;
      if (gnt0 || gnt1) begin
        cur_id = gnt1 ? 1 : 0;
        if (gseen > 0) begin
          check("alt_order",   cur_id, 1 - prev_id);
          check("alt_spacing", k - prev_k, 3);
        end
        prev_id = cur_id;
        prev_k  = k;
        gseen++;
        chg  = cur_id;
        pend = 1;
      end
      tick();
      if (pend) begin
        a_t[chg]  = rand_operand();
        b_t[chg]  = rand_operand();
        op_t[chg] = 3'($urandom_range(0, 7));
      end
    end
    req_t[0] = 1'b0;
    req_t[1] = 1'b0;
    check("alt_grant_count", gseen, 6);
    repeat (5) tick();

    // Ack withheld for 10 cycles: result and status hold, no new grant
    q_ack = 1'b0;
    set_req(0, 32'd0, $urandom, 3'b111);
    wait_gnt(0, got);
    tick();
    req_t[0] = 1'b0;
    set_req(1, rand_operand(), rand_operand(), 3'($urandom_range(0, 7)));
    @(negedge clk);
    check("hold_q_first", q, 32'hFFFF_FFFF);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("hold_q_valid", q_valid, 1);
      check("hold_q",       q,       32'hFFFF_FFFF);
      check("hold_q_id",    q_id,    0);
      check("hold_busy",    busy,    1);
      check("hold_no_gnt1", gnt1,    0);
    end
    tick();
    q_ack = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("ack_q_valid_clear", q_valid, 0);
    check("ack_busy_clear",    busy,    0);
    check("ack_q_kept",        q,       32'hFFFF_FFFF);
    wait_gnt(1, got);
    tick();
    req_t[1] = 1'b0;
    repeat (4) tick();

    // Reset while in EXEC: operation aborted, pointer restored
    set_req(0, rand_operand(), rand_operand(), 3'($urandom_range(0, 7)));
    wait_gnt(0, got);
    #1;
    rst      = 1'b1;
    req_t[0] = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    rst = 1'b0;
    @(negedge clk);
    check("abort_q_valid", q_valid, 0);
    check("abort_busy",    busy,    0);
    check("abort_q",       q,       0);
    check("abort_q_id",    q_id,    0);
    check("abort_alu_a",   alu_a,   0);
    check("abort_alu_op",  alu_op,  0);
    tick();
    set_req(0, rand_operand(), rand_operand(), 3'($urandom_range(0, 7)));
    set_req(1, rand_operand(), rand_operand(), 3'($urandom_range(0, 7)));
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (gnt0 || gnt1) seen = 1;
    end
    check("abort_tie_seen", seen, 1);
    check("abort_tie_gnt0", gnt0, 1);
    check("abort_tie_gnt1", gnt1, 0);
    tick();
    req_t[0] = 1'b0;
    req_t[1] = 1'b0;
    repeat (5) tick();

    // Randomized traffic: both requesters, all opcodes, random ack delay
    fork
      begin
        fork
          drive_rand(0, 40);
          drive_rand(1, 40);
        join
        rand_done = 1;
      end
      begin
        while (!rand_done) begin
          tick();
          q_ack = ($urandom_range(0, 2) == 0);
        end
      end
    join
    q_ack = 1'b1;
    repeat (10) tick();
    @(negedge clk);
    check("sb_drained", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
